ov7670_init_seq: RTL
====================

Name: ov7670_init_seq

Overview:
Power-up register-initialisation sequencer for the OV7670 camera. Walks a fixed table of (register address, data) pairs and drives the SCCB write engine one write at a time using a request/finish handshake. Inserts the power-up delay and the post-soft-reset (COM7 bit7) delay, times out stalled transfers with bounded retry, and flags completion so the capture path can be released.

Parameters:
REG_NUM, 4, number of table entries; the engine issues exactly REG_NUM writes.
PWRUP_DELAY, 10, cycles waited after start before the first write.
RESET_DELAY, 20, cycles waited after any write to address 8'h12 with data bit7 = 1.
TIMEOUT, 50, cycles allowed from write_en to data_finish.
MAX_RETRY, 2, retries per entry after a timeout before error.
AUTO_START, 1, if 1 the sequence starts automatically on reset release.

Ports:
sclk  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; starts or restarts the sequence from IDLE, DONE or ERROR
sccb_ready  input  1  SCCB engine idle and able to accept a write
data_finish  input  1  one-cycle pulse from the SCCB engine when the current write completes
write_en  output  1  one-cycle request pulse to the SCCB engine
sccb_addr  output  8  register address of the current write
sccb_data  output  8  register data of the current write
reg_idx  output  clog2(REG_NUM+1)  index of the entry in progress
busy  output  1  high in every state except IDLE, DONE and ERROR
init_done  output  1  high in DONE
init_err  output  1  high in ERROR

Behaviour:
- Reset (async assert, sync release): state IDLE; write_en 0; sccb_addr and sccb_data 8'h00; reg_idx 0; busy, init_done and init_err 0; all counters 0.
- IDLE -> PWRUP: on start, or on the first cycle after reset when AUTO_START = 1.
- PWRUP: count PWRUP_DELAY cycles, then go to FETCH with reg_idx = 0.
- FETCH: latch the table entry at reg_idx into sccb_addr and sccb_data, then go to ISSUE. The latched values stay stable until the next FETCH.
- ISSUE: wait for sccb_ready = 1. In that cycle assert write_en for exactly one cycle, clear the timeout counter, and go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - data_finish = 1: go to POST.
  - Counter reaches TIMEOUT without data_finish: increment the retry count and go back to ISSUE with the same addr and data.
  - Retry count exceeds MAX_RETRY: go to ERROR.
  - data_finish in the same cycle as the timeout: data_finish wins.
- POST: reset the retry count.
  - If sccb_addr = 8'h12 and sccb_data[7] = 1, wait RESET_DELAY cycles before continuing; otherwise continue after 0 extra cycles.
  - Then increment reg_idx. If reg_idx reaches REG_NUM, go to DONE; otherwise go to FETCH.
- DONE and ERROR: hold outputs. start re-enters PWRUP with reg_idx, retry count and flags cleared.
- start while busy: ignored.
- data_finish outside WAIT: ignored.
- Reset mid-transfer: the engine returns to IDLE immediately; write_en is never asserted while rst = 1.
- Latency, ideal engine (sccb_ready = 1, data_finish F cycles after write_en): first write_en occurs PWRUP_DELAY + 2 cycles after leaving IDLE.
- Counter widths are sized by clog2 of the largest of TIMEOUT, RESET_DELAY and PWRUP_DELAY; no wrap-around is possible.

Decomposition:
- Shared package ov7670_pkg holds:
  - state enum (IDLE, PWRUP, FETCH, ISSUE, WAIT, POST, DONE, ERROR);
  - COM7_ADDR = 8'h12 and COM7_RESET_BIT = 7;
  - the table entry typedef {addr[7:0], data[7:0]}.
- One sub-module, ov7670_reg_rom: combinational lookup, index -> 16-bit {addr, data}.
  - Test table: 0: 12/80, 1: 11/01, 2: 0C/04, 3: 3E/19.
  - Out-of-range index returns 16'hFFFF.

Test Plan:
- Nominal run with AUTO_START = 1 and an engine model returning data_finish 5 cycles after write_en -> four write_en pulses carrying 12/80, 11/01, 0C/04, 3E/19 in order; init_done rises; init_err stays 0.
- COM7 reset delay -> the gap between data_finish of entry 0 and write_en of entry 1 is ≥ 20 cycles; the gaps after other entries are ≤ 3 cycles.
- Handshake stall: hold sccb_ready = 0 for 30 cycles at entry 2 -> write_en is withheld, addr/data stay at 0C/04, and write_en fires in the first cycle sccb_ready = 1.
- Timeout and retry: drop data_finish once on entry 1 -> write_en for 11/01 repeats after 50 cycles, then the sequence completes with init_done = 1.
- Permanent failure: never assert data_finish on entry 1 -> exactly 3 write_en pulses for 11/01, then init_err = 1, busy = 0, reg_idx = 1.
- Reset mid-WAIT and restart: assert rst during entry 2 -> all outputs return to their reset values asynchronously; after release the sequence restarts at 12/80. A start pulse from DONE reruns all 4 writes.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 register-initialisation sequencer.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWRUP = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_POST  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERROR = 3'd7
  } state_e;

  localparam logic [7:0]  COM7_ADDR      = 8'h12;
  localparam int unsigned COM7_RESET_BIT = 7;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } reg_entry_t;

  // A COM7 write with the reset bit set soft-resets the sensor and needs settling time.
  function automatic logic is_soft_reset(input reg_entry_t e);
    return (e.addr == COM7_ADDR) && e.data[COM7_RESET_BIT];
  endfunction

  function automatic logic is_busy_state(input state_e s);
    logic b;
    case (s)
      ST_IDLE, ST_DONE, ST_ERROR: b = 1'b0;
      default:                    b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational register table: entry index -> {addr, data}; out-of-range reads all ones.
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx_i,
  output reg_entry_t       entry_o
);

  // Table lookup
  always_comb begin
    case (idx_i)
      IDX_W'(0): entry_o = reg_entry_t'(16'h1280);
      IDX_W'(1): entry_o = reg_entry_t'(16'h1101);
      IDX_W'(2): entry_o = reg_entry_t'(16'h0C04);
      IDX_W'(3): entry_o = reg_entry_t'(16'h3E19);
      default:   entry_o = reg_entry_t'(16'hFFFF);
    endcase
  end

endmodule

// File: rtl/ov7670_init_seq.sv
// OV7670 power-up sequencer: walks the register table and hands one write at a time to
// the SCCB engine, with power-up and soft-reset delays and bounded timeout retry.
module ov7670_init_seq
  import ov7670_pkg::*;
#(
  parameter int REG_NUM     = 4,
  parameter int PWRUP_DELAY = 10,
  parameter int RESET_DELAY = 20,
  parameter int TIMEOUT     = 50,
  parameter int MAX_RETRY   = 2,
  parameter int AUTO_START  = 1
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sccb_ready,
  input  logic                       data_finish,
  output logic                       write_en,
  output logic [7:0]                 sccb_addr,
  output logic [7:0]                 sccb_data,
  output logic [$clog2(REG_NUM+1)-1:0] reg_idx,
  output logic                       busy,
  output logic                       init_done,
  output logic                       init_err
);

  localparam int IDX_W   = $clog2(REG_NUM + 1);
  localparam int MAX_DLY = (TIMEOUT > RESET_DELAY)
                         ? ((TIMEOUT > PWRUP_DELAY) ? TIMEOUT : PWRUP_DELAY)
                         : ((RESET_DELAY > PWRUP_DELAY) ? RESET_DELAY : PWRUP_DELAY);
  localparam int CNT_W   = $clog2(MAX_DLY + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  reg_entry_t         cur_q, cur_d;
  reg_entry_t         rom_entry;
  logic               busy_q, done_q, err_q;

  ov7670_reg_rom #(.IDX_W(IDX_W)) u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  // Next-state logic; one counter serves power-up delay, write timeout and reset delay
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rty_d   = rty_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (start || (AUTO_START != 0)) begin
          state_d = ST_PWRUP;
          cnt_d   = '0;
          rty_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PWRUP: begin
        if (cnt_q == CNT_W'(PWRUP_DELAY - 1)) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FETCH: begin
        cur_d   = rom_entry;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (sccb_ready) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (data_finish) begin
          state_d = ST_POST;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          rty_d   = rty_q + RTY_W'(1);
          state_d = (rty_q == RTY_W'(MAX_RETRY)) ? ST_ERROR : ST_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_POST: begin
        rty_d = '0;
        if (is_soft_reset(cur_q) && (cnt_q != CNT_W'(RESET_DELAY))) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = (idx_q == IDX_W'(REG_NUM - 1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_PWRUP;
          cnt_d   = '0;
          rty_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rty_q   <= '0;
      idx_q   <= '0;
      cur_q   <= reg_entry_t'(16'h0000);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      busy_q  <= is_busy_state(state_d);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERROR);
    end
  end

  // The request is issued in the very cycle the engine reports ready.
  assign write_en  = (state_q == ST_ISSUE) && sccb_ready;
  assign sccb_addr = cur_q.addr;
  assign sccb_data = cur_q.data;
  assign reg_idx   = idx_q;
  assign busy      = busy_q;
  assign init_done = done_q;
  assign init_err  = err_q;

endmodule
